dm_access_ctrl: RTL and testbench
=================================

Name: dm_access_ctrl

Overview:
- M-stage memory access controller. It sits directly downstream of the store byte-lane formatter, which supplies m_data_byteen and the lane-aligned store data.
- Issues a single-outstanding request/acknowledge transaction to a variable-latency data bus.
- Stalls the pipeline while the access is in flight.
- Sign/zero-extends load data and presents the result to the W stage.
- Enforces a bus timeout.

Parameters:
MAX_WAIT, 16, cycles in REQ without bus_ack before timeout error (>=2)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
m_valid  input  1  M-stage instruction valid
m_is_load  input  1  M instruction is a load
m_is_store  input  1  M instruction is a store
m_addr  input  32  byte address
m_data_byteen  input  4  store byte enables from the upstream formatter
m_wdata  input  32  lane-aligned store data
m_load_type  input  3  load kind (`ld_lw/`ld_lb/`ld_lbu/`ld_lh/`ld_lhu)
bus_req  output  1  request held until ack
bus_we  output  1  1 = write
bus_addr  output  32  word address {addr[31:2],2'b00}
bus_byteen  output  4  store: latched byteen; load: 4'b1111
bus_wdata  output  32  latched store data
bus_ack  input  1  one-cycle completion from memory
bus_rdata  input  32  read word, valid with bus_ack
stall  output  1  freeze F/D/E/M stages
w_valid  output  1  one-cycle pulse: access finished
w_rdata  output  32  extended load result (0 for stores/errors)
exc_adel  output  1  load misaligned (combinational, M stage)
exc_ades  output  1  store byteen illegal (combinational, M stage)
bus_err  output  1  one-cycle pulse on timeout

Behaviour:
- Reset values: state IDLE; bus_req/bus_we/bus_err/w_valid = 0; bus_addr/bus_byteen/bus_wdata/w_rdata = 0; wait counter = 0.
- start = state==IDLE & m_valid & (m_is_load | m_is_store) & ~exc_adel & ~exc_ades.
- exc_adel = m_valid & m_is_load & ((lw & addr[1:0]!=0) | ((lh|lhu) & addr[0])).
- exc_ades = m_valid & m_is_store & byteen not in {0001,0010,0100,1000,0011,1100,1111}.
- An excepting instruction never starts a bus access.
- States:
  - IDLE: on start, latch addr, byteen, wdata, load_type, we=m_is_store; next REQ.
  - REQ: bus_req=1; counter increments each cycle.
    - bus_ack: for loads, w_rdata <= ext(bus_rdata); for stores, w_rdata <= 0. Next DONE.
    - No ack with counter==MAX_WAIT-1: bus_err pulse; w_rdata <= 0; next DONE.
  - DONE: w_valid=1 and bus_req=0 for exactly one cycle; next IDLE. m_valid is ignored in DONE, because the completed instruction is still present.
- stall = start | (state==REQ). It is combinational, so it rises in the issue cycle and falls in the DONE cycle.
- Minimum latency: issue cycle + 1 REQ cycle (ack on first REQ cycle) + DONE = 3 cycles.
- Bus outputs are registered and stable throughout REQ. bus_ack outside REQ is ignored.
- Extension uses latched addr[1:0]:
  - lb/lbu select byte addr[1:0].
  - lh/lhu select halfword addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
- Ack and timeout in the same cycle: ack wins, no bus_err.
- Reset mid-REQ: next edge returns to IDLE and drops bus_req. No w_valid. The in-flight ack is discarded.
- Back-to-back accesses: a new start is possible in the IDLE cycle right after DONE.

Decomposition:
- constants.v (shared): `ld_lw=0, `ld_lb=1, `ld_lbu=2, `ld_lh=3, `ld_lhu=4; state encodings `DMA_IDLE/`DMA_REQ/`DMA_DONE.
- Sub-module load_ext: combinational (rdata, addr[1:0], load_type) -> 32-bit extended value, reusable by W-stage forwarding.

Test Plan:
- Store, ack after 3 REQ cycles: sb addr 0x1002, byteen 0100, wdata 0x00AB0000 -> bus_req 3 cycles, bus_addr 0x1000, bus_we=1; stall high 4 cycles; w_valid pulse; w_rdata 0.
- lb addr 0x2003, bus_rdata 0x80FF1234, ack first REQ cycle -> w_rdata 0xFFFFFF80; lbu on the same data -> 0x00000080; total latency 3 cycles.
- lh addr 0x2002, rdata 0x8001_7FFF -> 0xFFFF8001; lhu -> 0x00008001; lw addr 0x2000 -> 0x80017FFF.
- Misaligned: lw addr 0x3001 -> exc_adel=1, no bus_req, stall=0. Store byteen 0110 -> exc_ades=1, no access.
- Timeout with MAX_WAIT=16, no ack -> bus_err pulses on the 16th REQ cycle, then w_valid with w_rdata 0, stall drops. Separate run with ack on that same cycle -> no bus_err, data returned.
- Reset asserted on the 2nd REQ cycle -> next cycle bus_req=0 and stall=0. A late ack produces no w_valid. A following lw at 0x4000 completes normally.

Source files
------------

// File: rtl/dm_access_ctrl_pkg.sv
// Shared types and helpers for the M-stage data memory access controller:
// FSM state encoding, load-type codes and the legality checks for exceptions.
package dm_access_ctrl_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE = 2'd0,
    DMA_REQ  = 2'd1,
    DMA_DONE = 2'd2
  } dma_state_e;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  // Only naturally aligned byte, halfword and word enables are accepted.
  function automatic logic byteen_legal(input logic [3:0] be);
    logic ok;
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic load_misaligned(input logic [2:0] lt, input logic [1:0] a);
    logic mis;
    case (lt)
      LD_LW:         mis = (a != 2'b00);
      LD_LH, LD_LHU: mis = a[0];
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Single-outstanding request/acknowledge data bus between the access
// controller (master) and the variable-latency memory (slave).
interface dm_access_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dm_access_ctrl_load_ext.sv
// Combinational load extender: picks the byte/halfword addressed by the low
// address bits and sign- or zero-extends it. Also usable by W-stage forwarding.
module dm_access_ctrl_load_ext
  import dm_access_ctrl_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_load_type,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  // Extension select by load kind.
  always_comb begin
    o_data = i_rdata;
    case (i_load_type)
      LD_LW:   o_data = i_rdata;
      LD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  o_data = {24'h00_0000, w_byte};
      LD_LH:   o_data = {{16{w_half[15]}}, w_half};
      LD_LHU:  o_data = {16'h0000, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// M-stage memory access controller: issues one bus transaction per load/store,
// stalls the pipeline while it is in flight, times out, and extends load data.
module dm_access_ctrl
  import dm_access_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m_valid,
  input  logic                  m_is_load,
  input  logic                  m_is_store,
  input  logic [31:0]           m_addr,
  input  logic [3:0]            m_data_byteen,
  input  logic [31:0]           m_wdata,
  input  logic [2:0]            m_load_type,
  dm_access_ctrl_if.master      bus,
  output logic                  stall,
  output logic                  w_valid,
  output logic [31:0]           w_rdata,
  output logic                  exc_adel,
  output logic                  exc_ades,
  output logic                  bus_err
);

  localparam int CW = $clog2(MAX_WAIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  dma_state_e  r_state;
  dma_state_e  w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_addr;
  logic [3:0]  r_byteen;
  logic [31:0] r_wdata;
  logic [2:0]  r_ld_type;
  logic        r_we;
  logic [31:0] r_w_rdata;
  logic        w_start;
  logic        w_ack;
  logic        w_tmo;
  logic [31:0] w_ext;

  assign exc_adel = m_valid & m_is_load & load_misaligned(m_load_type, m_addr[1:0]);
  assign exc_ades = m_valid & m_is_store & ~byteen_legal(m_data_byteen);
  assign w_start  = (r_state == DMA_IDLE) & m_valid & (m_is_load | m_is_store)
                    & ~exc_adel & ~exc_ades;

  assign stall          = w_start | (r_state == DMA_REQ);
  assign bus.bus_req    = (r_state == DMA_REQ);
  assign bus.bus_we     = r_we;
  assign bus.bus_addr   = {r_addr[31:2], 2'b00};
  assign bus.bus_byteen = r_byteen;
  assign bus.bus_wdata  = r_wdata;
  assign w_valid        = (r_state == DMA_DONE);
  assign w_rdata        = r_w_rdata;
  // Timeout flag is raised during the last REQ cycle itself; an ack that cycle wins.
  assign bus_err        = w_tmo;

  dm_access_ctrl_load_ext u_load_ext (
    .i_rdata     (bus.bus_rdata),
    .i_addr_lo   (r_addr[1:0]),
    .i_load_type (r_ld_type),
    .o_data      (w_ext)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= DMA_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and completion decode; the ack is only honoured in REQ.
  always_comb begin
    w_state_nxt = r_state;
    w_ack       = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      DMA_IDLE: begin
        if (w_start) w_state_nxt = DMA_REQ;
        else         w_state_nxt = DMA_IDLE;
      end
      DMA_REQ: begin
        if (bus.bus_ack) begin
          w_ack       = 1'b1;
          w_state_nxt = DMA_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = DMA_DONE;
        end else begin
          w_state_nxt = DMA_REQ;
        end
      end
      DMA_DONE: w_state_nxt = DMA_IDLE;
      default:  w_state_nxt = DMA_IDLE;
    endcase
  end

  // Request latching, wait counter and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_addr    <= 32'h0000_0000;
      r_byteen  <= 4'b0000;
      r_wdata   <= 32'h0000_0000;
      r_ld_type <= 3'd0;
      r_we      <= 1'b0;
      r_w_rdata <= 32'h0000_0000;
    end else begin
      case (r_state)
        DMA_IDLE: begin
          if (w_start) begin
            r_cnt     <= '0;
            r_addr    <= m_addr;
            r_byteen  <= m_is_store ? m_data_byteen : 4'b1111;
            r_wdata   <= m_is_store ? m_wdata : 32'h0000_0000;
            r_ld_type <= m_load_type;
            r_we      <= m_is_store;
          end
        end
        DMA_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_ack)      r_w_rdata <= r_we ? 32'h0000_0000 : w_ext;
          else if (w_tmo) r_w_rdata <= 32'h0000_0000;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: directed plan scenarios followed by
// randomized loads/stores against an arithmetic reference model.
module tb_dm_access_ctrl;

  localparam int MAX_WAIT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  logic        m_is_load;
  logic        m_is_store;
  logic [31:0] m_addr;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_wdata;
  logic [2:0]  m_load_type;
  logic        stall;
  logic        w_valid;
  logic [31:0] w_rdata;
  logic        exc_adel;
  logic        exc_ades;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;

  dm_access_ctrl_if bus_if ();

  dm_access_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk           (clk),
    .reset         (reset),
    .m_valid       (m_valid),
    .m_is_load     (m_is_load),
    .m_is_store    (m_is_store),
    .m_addr        (m_addr),
    .m_data_byteen (m_data_byteen),
    .m_wdata       (m_wdata),
    .m_load_type   (m_load_type),
    .bus           (bus_if),
    .stall         (stall),
    .w_valid       (w_valid),
    .w_rdata       (w_rdata),
    .exc_adel      (exc_adel),
    .exc_ades      (exc_ades),
    .bus_err       (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [31:0] rd, input int off, input int lt);
    int unsigned b;
    int unsigned h;
    b = (rd >> (8 * off)) & 32'h0000_00FF;
    h = (rd >> (16 * (off / 2))) & 32'h0000_FFFF;
    case (lt)
      1:       return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
      2:       return b;
      3:       return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      4:       return h;
      default: return rd;
    endcase
  endfunction

  function automatic bit ref_be_ok(input logic [3:0] be);
    logic [3:0] legal [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    for (int i = 0; i < 7; i++) if (be == legal[i]) return 1'b1;
    return 1'b0;
  endfunction

  // One access starting in the next cycle; ack_at = REQ cycle of ack, 0 = never.
  task automatic do_access(input bit ld, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, input int lt, input int ack_at,
                           input logic [31:0] rd, input string tag);
    int  off;
    bit  adel;
    bit  ades;
    bit  fin;
    logic [31:0] exp_rd;
    off  = int'(addr % 4);
    adel = ld && ((lt == 0 && off != 0) || ((lt == 3 || lt == 4) && (off % 2) == 1));
    ades = !ld && !ref_be_ok(be);
    @(posedge clk); #1;
    m_valid = 1'b1; m_is_load = ld; m_is_store = !ld; m_addr = addr;
    m_data_byteen = be; m_wdata = wd; m_load_type = lt[2:0];
    @(negedge clk);
    chk({tag, ".adel"}, 32'(exc_adel), 32'(adel));
    chk({tag, ".ades"}, 32'(exc_ades), 32'(ades));
    chk({tag, ".stall_issue"}, 32'(stall), 32'(!(adel || ades)));
    if (adel || ades) begin
      @(posedge clk); #1;
      m_valid = 1'b0;
      @(negedge clk);
      chk({tag, ".no_req"}, 32'(bus_if.bus_req), 32'd0);
      chk({tag, ".no_wvalid"}, 32'(w_valid), 32'd0);
    end else begin
      exp_rd = (ld && ack_at >= 1 && ack_at <= MAX_WAIT) ? ref_ext(rd, off, lt) : 32'd0;
      fin = 1'b0;
      for (int k = 1; k <= MAX_WAIT && !fin; k++) begin
        @(posedge clk); #1;
        bus_if.bus_ack   = (k == ack_at);
        bus_if.bus_rdata = (k == ack_at) ? rd : $urandom;
        @(negedge clk);
        chk({tag, ".req"}, 32'(bus_if.bus_req), 32'd1);
        chk({tag, ".stall_req"}, 32'(stall), 32'd1);
        chk({tag, ".we"}, 32'(bus_if.bus_we), 32'(!ld));
        chk({tag, ".addr"}, bus_if.bus_addr, addr & 32'hFFFF_FFFC);
        chk({tag, ".byteen"}, 32'(bus_if.bus_byteen), ld ? 32'hF : 32'(be));
        chk({tag, ".wdata"}, bus_if.bus_wdata, ld ? 32'd0 : wd);
        chk({tag, ".bus_err"}, 32'(bus_err), 32'(k == MAX_WAIT && k != ack_at));
        chk({tag, ".wvalid_req"}, 32'(w_valid), 32'd0);
        if (k == ack_at || k == MAX_WAIT) fin = 1'b1;
      end
      @(posedge clk); #1;
      bus_if.bus_ack = 1'b0;
      @(negedge clk);
      chk({tag, ".wvalid"}, 32'(w_valid), 32'd1);
      chk({tag, ".req_done"}, 32'(bus_if.bus_req), 32'd0);
      chk({tag, ".stall_done"}, 32'(stall), 32'd0);
      chk({tag, ".err_done"}, 32'(bus_err), 32'd0);
      chk({tag, ".wrdata"}, w_rdata, exp_rd);
    end
  endtask

  initial begin
    int lt;
    int r;
    int ack_at;
    bit ld;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [3:0]  legal [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    reset = 1'b1; m_valid = 1'b0; m_is_load = 1'b0; m_is_store = 1'b0;
    m_addr = 32'd0; m_data_byteen = 4'd0; m_wdata = 32'd0; m_load_type = 3'd0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst.req", 32'(bus_if.bus_req), 32'd0);
    chk("rst.we", 32'(bus_if.bus_we), 32'd0);
    chk("rst.addr", bus_if.bus_addr, 32'd0);
    chk("rst.byteen", 32'(bus_if.bus_byteen), 32'd0);
    chk("rst.wdata", bus_if.bus_wdata, 32'd0);
    chk("rst.wvalid", 32'(w_valid), 32'd0);
    chk("rst.wrdata", w_rdata, 32'd0);
    chk("rst.err", 32'(bus_err), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);

    do_access(1'b0, 32'h0000_1002, 4'b0100, 32'h00AB_0000, 1, 3, 32'd0, "sb");
    do_access(1'b1, 32'h0000_2003, 4'b0000, 32'd0, 1, 1, 32'h80FF_1234, "lb");
    do_access(1'b1, 32'h0000_2003, 4'b0000, 32'd0, 2, 1, 32'h80FF_1234, "lbu");
    do_access(1'b1, 32'h0000_2002, 4'b0000, 32'd0, 3, 2, 32'h8001_7FFF, "lh");
    do_access(1'b1, 32'h0000_2002, 4'b0000, 32'd0, 4, 1, 32'h8001_7FFF, "lhu");
    do_access(1'b1, 32'h0000_2000, 4'b0000, 32'd0, 0, 1, 32'h8001_7FFF, "lw");
    do_access(1'b1, 32'h0000_3001, 4'b0000, 32'd0, 0, 1, 32'd0, "lw_mis");
    do_access(1'b0, 32'h0000_3000, 4'b0110, 32'h1234_5678, 0, 1, 32'd0, "st_bad");
    do_access(1'b1, 32'h0000_2000, 4'b0000, 32'd0, 0, 0, 32'd0, "tmo");
    do_access(1'b1, 32'h0000_2001, 4'b0000, 32'd0, 2, MAX_WAIT, 32'hA5C3_E10F, "ack_last");

    // Reset during the second REQ cycle, followed by a stray ack.
    @(posedge clk); #1;
    m_valid = 1'b1; m_is_load = 1'b1; m_is_store = 1'b0; m_addr = 32'h0000_5000; m_load_type = 3'd0;
    @(negedge clk);
    chk("rstreq.stall_issue", 32'(stall), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstreq.req1", 32'(bus_if.bus_req), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1; m_valid = 1'b0;
    @(negedge clk);
    chk("rstreq.req2", 32'(bus_if.bus_req), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0; bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rstreq.req_off", 32'(bus_if.bus_req), 32'd0);
    chk("rstreq.stall_off", 32'(stall), 32'd0);
    chk("rstreq.wvalid0", 32'(w_valid), 32'd0);
    @(posedge clk); #1;
    bus_if.bus_ack = 1'b0;
    @(negedge clk);
    chk("rstreq.wvalid1", 32'(w_valid), 32'd0);
    do_access(1'b1, 32'h0000_4000, 4'b0000, 32'd0, 0, 2, 32'hCAFE_F00D, "lw_after_rst");

    for (int i = 0; i < 30; i++) begin
      ld   = 1'($urandom_range(0, 1));
      lt   = int'($urandom_range(0, 4));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (lt == 0) addr[1:0] = 2'b00;
        if (lt >= 3) addr[0] = 1'b0;
      end
      be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal[$urandom_range(0, 6)];
      r  = int'($urandom_range(0, 9));
      ack_at = (r == 0) ? 0 : (r == 1) ? MAX_WAIT : int'($urandom_range(1, 4));
      do_access(ld, addr, be, $urandom, lt, ack_at, $urandom, "rnd");
    end

    @(posedge clk); #1;
    m_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
